// File: rtl/macc_accum.sv
// macc_accum: streaming signed multiply-accumulate producing one dot product
// per 'last'-terminated run of samples.
//
// Pipeline: S1 operand register -> S2 product register -> S3 accumulator ->
// result register. A sample accepted at edge t shows its result after edge
// t+3. Downstream backpressure freezes every stage at once, so nothing is
// dropped and nothing moves while a result is waiting to be taken.
module macc_accum #(
  parameter int A_WIDTH   = 25,
  parameter int B_WIDTH   = 18,
  parameter int ACC_WIDTH = 48
) (
  input  logic                        clk,
  input  logic                        resetn,
  input  logic                        clr,
  input  logic                        in_valid,
  output logic                        in_ready,
  input  logic signed [A_WIDTH-1:0]   a,
  input  logic signed [B_WIDTH-1:0]   b,
  input  logic                        last,
  output logic                        out_valid,
  input  logic                        out_ready,
  output logic signed [ACC_WIDTH-1:0] acc_out,
  output logic                        ovf
);

  localparam int P_WIDTH = A_WIDTH + B_WIDTH;
  localparam int STAGES  = 3;

  // The product must fit the accumulator without truncation.
  generate
    if (ACC_WIDTH < P_WIDTH) begin : g_width_chk
      $error("macc_accum: ACC_WIDTH must be >= A_WIDTH + B_WIDTH");
    end
  endgenerate

  // Operand stage payload.
  typedef struct packed {
    logic [A_WIDTH-1:0] a;
    logic [B_WIDTH-1:0] b;
  } opnd_t;

  // Stage valid / last shift registers; index n is the output of stage Sn.
  logic [STAGES:1] vld_pipe_q, vld_pipe_d;
  logic [STAGES:1] lst_pipe_q, lst_pipe_d;

  // S1 / S2 data.
  opnd_t                       s1_q, s1_d;
  logic signed [P_WIDTH-1:0]   p_q, p_d;

  // S3 accumulator state.
  logic signed [ACC_WIDTH-1:0] acc_q, acc_d;
  logic                        s3_ovf_q, s3_ovf_d;
  logic                        first_q, first_d;
  logic                        sticky_q, sticky_d;

  // Result register.
  logic                        out_valid_q, out_valid_d;
  logic signed [ACC_WIDTH-1:0] acc_out_q, acc_out_d;
  logic                        ovf_q, ovf_d;

  // Handshake / datapath intermediates.
  logic                        stall;
  logic                        accept;
  logic signed [P_WIDTH-1:0]   prod;
  logic signed [ACC_WIDTH-1:0] p_ext;
  logic signed [ACC_WIDTH-1:0] addend;
  logic signed [ACC_WIDTH-1:0] sum;
  logic                        add_ovf;

  // Flow control: a held result freezes the pipe; clr also blocks intake.
  always_comb begin
    stall    = out_valid_q && !out_ready;
    in_ready = !stall && !clr;
    accept   = in_valid && in_ready;
  end

  // Arithmetic: full-width signed product, then wrap-around accumulate with
  // two's-complement overflow detection (operands same sign, result differs).
  always_comb begin
    prod    = $signed(s1_q.a) * $signed(s1_q.b);
    p_ext   = ACC_WIDTH'(p_q);
    addend  = first_q ? '0 : acc_q;
    sum     = addend + p_ext;
    add_ovf = (addend[ACC_WIDTH-1] == p_ext[ACC_WIDTH-1]) &&
              (sum[ACC_WIDTH-1] != addend[ACC_WIDTH-1]);
  end

  // Valid/last shift and S1/S2 data capture.
  always_comb begin
    vld_pipe_d = vld_pipe_q;
    lst_pipe_d = lst_pipe_q;
    s1_d       = s1_q;
    p_d        = p_q;
    if (clr) begin
      vld_pipe_d = '0;
      lst_pipe_d = '0;
    end else if (!stall) begin
      vld_pipe_d = {vld_pipe_q[STAGES-1:1], accept};
      lst_pipe_d = {lst_pipe_q[STAGES-1:1], accept && last};
      if (accept) begin
        s1_d.a = a;
        s1_d.b = b;
      end
      if (vld_pipe_q[1]) p_d = prod;
    end
  end

  // S3: fold the product into the running sum; 'first' restarts the sum and
  // the sticky overflow after each completed dot product.
  always_comb begin
    acc_d    = acc_q;
    s3_ovf_d = s3_ovf_q;
    first_d  = first_q;
    sticky_d = sticky_q;
    if (clr) begin
      acc_d    = '0;
      s3_ovf_d = 1'b0;
      first_d  = 1'b1;
      sticky_d = 1'b0;
    end else if (!stall && vld_pipe_q[2]) begin
      acc_d    = sum;
      s3_ovf_d = sticky_q || add_ovf;
      first_d  = lst_pipe_q[2];
      sticky_d = lst_pipe_q[2] ? 1'b0 : (sticky_q || add_ovf);
    end
  end

  // Result register: loads when a 'last' sample leaves S3; otherwise an
  // unstalled cycle means any previous result was taken, so valid drops.
  always_comb begin
    out_valid_d = out_valid_q;
    acc_out_d   = acc_out_q;
    ovf_d       = ovf_q;
    if (clr) begin
      out_valid_d = 1'b0;
      ovf_d       = 1'b0;
    end else if (!stall) begin
      out_valid_d = vld_pipe_q[3] && lst_pipe_q[3];
      if (vld_pipe_q[3] && lst_pipe_q[3]) begin
        acc_out_d = acc_q;
        ovf_d     = s3_ovf_q;
      end
    end
  end

  // State registers with asynchronous active-low reset.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      vld_pipe_q  <= '0;
      lst_pipe_q  <= '0;
      s1_q        <= '0;
      p_q         <= '0;
      acc_q       <= '0;
      s3_ovf_q    <= 1'b0;
      first_q     <= 1'b1;
      sticky_q    <= 1'b0;
      out_valid_q <= 1'b0;
      acc_out_q   <= '0;
      ovf_q       <= 1'b0;
    end else begin
      vld_pipe_q  <= vld_pipe_d;
      lst_pipe_q  <= lst_pipe_d;
      s1_q        <= s1_d;
      p_q         <= p_d;
      acc_q       <= acc_d;
      s3_ovf_q    <= s3_ovf_d;
      first_q     <= first_d;
      sticky_q    <= sticky_d;
      out_valid_q <= out_valid_d;
      acc_out_q   <= acc_out_d;
      ovf_q       <= ovf_d;
    end
  end

  assign out_valid = out_valid_q;
  assign acc_out   = acc_out_q;
  assign ovf       = ovf_q;

endmodule

// File: tb/tb_macc_accum.sv
// tb_macc_accum: directed scenarios plus randomized traffic with backpressure,
// checked against a dot-product reference model (exact arithmetic, wrap and
// overflow by range test, results queued in order).
module tb_macc_accum;

  localparam int AW = 25;
  localparam int BW = 18;
  localparam int CW = 48;
  localparam longint MAXA = (64'sd1 <<< (CW-1)) - 1;
  localparam longint MINA = -(64'sd1 <<< (CW-1));

  logic clk = 1'b0;
  logic resetn = 1'b0;
  logic clr = 1'b0;
  logic in_valid = 1'b0;
  logic last = 1'b0;
  logic out_ready = 1'b0;
  logic signed [AW-1:0] a = '0;
  logic signed [BW-1:0] b = '0;
  logic in_ready, out_valid, ovf;
  logic signed [CW-1:0] acc_out;

  macc_accum #(.A_WIDTH(AW), .B_WIDTH(BW), .ACC_WIDTH(CW)) dut (
    .clk(clk), .resetn(resetn), .clr(clr), .in_valid(in_valid),
    .in_ready(in_ready), .a(a), .b(b), .last(last), .out_valid(out_valid),
    .out_ready(out_ready), .acc_out(acc_out), .ovf(ovf)
  );

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_fail = 0;
  int cyc = 0;

  typedef struct { longint val; bit o; } res_t;
  res_t q[$];
  longint run = 0;
  bit first = 1'b1;
  bit stk = 1'b0;

  int acc_cyc = 0;
  int hs_cyc = 0;
  longint hs_val = 0;
  bit hs_ovf = 1'b0;
  bit hs_got = 1'b0;

  task automatic chk(input string tag, input logic signed [63:0] got,
                     input logic signed [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  function automatic longint wrap(input longint x);
    longint t;
    t = x <<< (64 - CW);
    return t >>> (64 - CW);
  endfunction

  function automatic void model_reset();
    q.delete();
    run = 0;
    first = 1'b1;
    stk = 1'b0;
  endfunction

  // Dot-product rules: start from zero on the first sample, wrap modulo
  // 2^CW, overflow when the exact sum leaves the signed range.
  function automatic void model_accept(input longint p, input bit l);
    longint s, t;
    bit o;
    s = first ? 64'sd0 : run;
    t = s + p;
    o = (t > MAXA) || (t < MINA);
    run = wrap(t);
    stk = stk | o;
    if (l) begin
      q.push_back('{run, stk});
      first = 1'b1;
      stk = 1'b0;
    end else begin
      first = 1'b0;
    end
  endfunction

  // Sampled 1 time unit after the falling edge, i.e. mid-cycle.
  task automatic observe();
    bit exp_rdy;
    longint p;
    exp_rdy = !(out_valid && !out_ready) && !clr;
    chk("in_ready", in_ready, exp_rdy);
    hs_got = 1'b0;
    if (out_valid) begin
      if (q.size() == 0) begin
        chk("spurious_out_valid", out_valid, 0);
      end else begin
        chk("acc_out", acc_out, q[0].val);
        chk("ovf", ovf, q[0].o);
        if (out_ready) begin
          hs_got = 1'b1;
          hs_cyc = cyc;
          hs_val = acc_out;
          hs_ovf = ovf;
          void'(q.pop_front());
        end
      end
    end
    if (clr) begin
      model_reset();
    end else if (in_valid && in_ready) begin
      p = longint'(a) * longint'(b);
      model_accept(p, last);
      if (last) acc_cyc = cyc;
    end
  endtask

  task automatic step(input bit iv, input logic signed [AW-1:0] ia,
                      input logic signed [BW-1:0] ib, input bit il,
                      input bit ordy, input bit iclr);
    @(negedge clk);
    in_valid = iv; a = ia; b = ib; last = il; out_ready = ordy; clr = iclr;
    #1;
    observe();
    cyc++;
  endtask

  task automatic wait_out(input string tag, input longint ev, input bit eo);
    for (int i = 0; i < 12; i++) begin
      step(1'b0, '0, '0, 1'b0, 1'b1, 1'b0);
      if (hs_got) break;
    end
    chk({tag, "_seen"}, hs_got, 1);
    if (hs_got) begin
      chk({tag, "_val"}, hs_val, ev);
      chk({tag, "_ovf"}, hs_ovf, eo);
    end
  endtask

  task automatic drain(input string tag);
    for (int i = 0; i < 60 && q.size() != 0; i++)
      step(1'b0, '0, '0, 1'b0, 1'b1, 1'b0);
    chk({tag, "_pending"}, q.size(), 0);
  endtask

  initial begin
    logic signed [AW-1:0] ra;
    logic signed [BW-1:0] rb;

    // Reset state.
    #2;
    chk("rst_out_valid", out_valid, 0);
    chk("rst_acc_out", acc_out, 0);
    chk("rst_ovf", ovf, 0);
    repeat (2) @(negedge clk);
    resetn = 1'b1;
    #1;
    chk("rst_in_ready", in_ready, 1);

    // 3-sample dot product: 12 - 10 - 7 = -5. Observation points sit half a
    // cycle after each edge, so "valid after edge t+3" is 4 steps later.
    step(1, 3, 4, 0, 1, 0);
    step(1, -2, 5, 0, 1, 0);
    step(1, 7, -1, 1, 1, 0);
    wait_out("dot3", -5, 0);
    chk("dot3_latency", hs_cyc - acc_cyc, 4);

    // Back-to-back single-sample products on consecutive cycles.
    step(1, 2, 3, 1, 1, 0);
    step(1, 4, 5, 1, 1, 0);
    wait_out("bb1", 6, 0);
    step(0, 0, 0, 0, 1, 0);
    chk("bb2_seen", hs_got, 1);
    chk("bb2_val", hs_val, 20);

    // Backpressure: result held, intake keeps offering samples.
    step(1, 1, 1, 1, 0, 0);
    for (int i = 0; i < 8; i++) step(1, AW'(i + 2), 3, 1, 0, 0);
    chk("stall_out_valid", out_valid, 1);
    chk("stall_in_ready", in_ready, 0);
    chk("stall_acc_out", acc_out, 1);
    drain("stall");

    // 64 x 2^41 = 2^47 overflows the signed 48-bit accumulator.
    for (int i = 0; i < 64; i++)
      step(1, -(1 <<< 24), -(1 <<< 17), (i == 63), 1, 0);
    wait_out("ovf64", -(64'sd1 <<< 47), 1);

    // clr mid-product: partial sum and the sample presented with clr vanish.
    step(1, 5, 5, 0, 1, 0);
    step(1, 6, 6, 0, 1, 0);
    step(1, 9, 9, 1, 1, 1);
    step(1, 1, 1, 1, 1, 0);
    wait_out("after_clr", 1, 0);

    // Asynchronous reset between edges with a result pending and a partial
    // product in flight.
    step(1, 2, 2, 1, 0, 0);
    step(1, 3, 3, 0, 0, 0);
    step(1, 4, 4, 0, 0, 0);
    for (int i = 0; i < 3; i++) step(0, 0, 0, 0, 0, 0);
    chk("pre_rst_out_valid", out_valid, 1);
    #1 resetn = 1'b0;
    #1;
    chk("async_rst_out_valid", out_valid, 0);
    chk("async_rst_acc_out", acc_out, 0);
    chk("async_rst_ovf", ovf, 0);
    model_reset();
    @(negedge clk);
    @(negedge clk);
    resetn = 1'b1;
    step(1, 6, 7, 1, 1, 0);
    wait_out("post_rst", 42, 0);

    // Randomized traffic with bubbles, backpressure and occasional clr.
    for (int i = 0; i < 1500; i++) begin
      if ($urandom_range(7) == 0) begin
        ra = AW'($urandom);
        rb = BW'($urandom);
      end else begin
        ra = AW'(int'($urandom_range(2000)) - 1000);
        rb = BW'(int'($urandom_range(200)) - 100);
      end
      step(($urandom_range(3) != 0), ra, rb, ($urandom_range(3) == 0),
           ($urandom_range(9) < 7), ($urandom_range(149) == 0));
    end
    drain("random");

    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
    $finish;
  end

endmodule
